// File: rtl/bcd_seg_scan.sv
// bcd_seg_scan: drives six multiplexed seven-segment digits from a packed BCD word.
// The word is captured into a shadow register. It is copied to the display register only at
// frame boundaries, so the digits shown never change in the middle of a scan frame.
// Each digit slot begins with BLANK_CYCLES clocks with every anode off, to stop ghosting.
// Optional feature: define LEADING_ZERO_BLANK_EN to suppress leading zeros.
module bcd_seg_scan #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] bcd_in,
  input  logic        load,
  input  logic [5:0]  dp_mask,
  output logic [7:0]  seg,
  output logic [5:0]  an,
  output logic        frame_tick
);

  localparam int              PW        = $clog2(SCAN_DIV);
  localparam logic [PW-1:0]   PRESC_MAX = PW'(SCAN_DIV - 1);

  logic [PW-1:0] presc;
  logic [2:0]    slot;
  logic [23:0]   shadow;
  logic [23:0]   display;
  logic          presc_wrap;
  logic          frame_wrap;
  logic          in_blank;
  logic          lz_blank;
  logic [3:0]    digit;
  logic          dp_on;
  logic [5:0]    an_sel;

  assign presc_wrap = (presc == PRESC_MAX);
  assign frame_wrap = presc_wrap && (slot == 3'd5);
  assign in_blank   = (int'(presc) < BLANK_CYCLES);

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h40;
      4'd1:    decode = 7'h79;
      4'd2:    decode = 7'h24;
      4'd3:    decode = 7'h30;
      4'd4:    decode = 7'h19;
      4'd5:    decode = 7'h12;
      4'd6:    decode = 7'h02;
      4'd7:    decode = 7'h78;
      4'd8:    decode = 7'h00;
      4'd9:    decode = 7'h10;
      default: decode = 7'h3F;  // dash: only segment g lit
    endcase
  endfunction

  // Prescaler counts clocks within a slot; slot index advances on each prescaler wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      slot  <= 3'd0;
    end else if (presc_wrap) begin
      presc <= '0;
      slot  <= (slot == 3'd5) ? 3'd0 : slot + 3'd1;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Shadow register follows load; display register takes its new value only at the frame boundary.
  // A load in the boundary cycle itself goes straight into the display register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow     <= 24'h0;
      display    <= 24'h0;
      frame_tick <= 1'b0;
    end else begin
      if (load) shadow <= bcd_in;
      if (frame_wrap) display <= load ? bcd_in : shadow;
      frame_tick <= frame_wrap;
    end
  end

  // Select the digit, the decimal point and the anode pattern for the current slot.
  always_comb begin
    digit  = 4'h0;
    dp_on  = 1'b0;
    an_sel = 6'h3F;
    case (slot)
      3'd0: begin digit = display[3:0];   dp_on = dp_mask[0]; an_sel = 6'h3E; end
      3'd1: begin digit = display[7:4];   dp_on = dp_mask[1]; an_sel = 6'h3D; end
      3'd2: begin digit = display[11:8];  dp_on = dp_mask[2]; an_sel = 6'h3B; end
      3'd3: begin digit = display[15:12]; dp_on = dp_mask[3]; an_sel = 6'h37; end
      3'd4: begin digit = display[19:16]; dp_on = dp_mask[4]; an_sel = 6'h2F; end
      3'd5: begin digit = display[23:20]; dp_on = dp_mask[5]; an_sel = 6'h1F; end
      default: begin digit = 4'h0; dp_on = 1'b0; an_sel = 6'h3F; end
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [5:0] zero_up;

  // zero_up[k] is set when digit k and every digit above it are zero. A lit dp keeps its digit on.
  always_comb begin
    zero_up    = 6'h00;
    zero_up[5] = (display[23:20] == 4'h0);
    for (int k = 4; k >= 0; k--) begin
      zero_up[k] = zero_up[k+1] && (display[4*k +: 4] == 4'h0);
    end
    lz_blank = 1'b0;
    case (slot)
      3'd1: lz_blank = zero_up[1] && !dp_on;
      3'd2: lz_blank = zero_up[2] && !dp_on;
      3'd3: lz_blank = zero_up[3] && !dp_on;
      3'd4: lz_blank = zero_up[4] && !dp_on;
      3'd5: lz_blank = zero_up[5] && !dp_on;
      default: lz_blank = 1'b0;
    endcase
  end
`else
  assign lz_blank = 1'b0;
`endif

  // Registered pin drivers: all off during slot blanking or for a suppressed leading zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= 6'h3F;
      seg <= 8'hFF;
    end else if (in_blank || lz_blank) begin
      an  <= 6'h3F;
      seg <= 8'hFF;
    end else begin
      an  <= an_sel;
      seg <= {~dp_on, decode(digit)};
    end
  end

endmodule

// File: tb/tb_bcd_seg_scan.sv
// tb_bcd_seg_scan: directed bench for bcd_seg_scan with SCAN_DIV=8 and BLANK_CYCLES=2.
// Each test vector is a whole scan frame, checked clock by clock against hand-tabled segment codes.
module tb_bcd_seg_scan;

  localparam int SCAN_DIV = 8;
  localparam int BLANK    = 2;
  localparam int FRAME    = 6 * SCAN_DIV;

  logic        clk;
  logic        rst_n;
  logic [23:0] bcd_in;
  logic        load;
  logic [5:0]  dp_mask;
  logic [7:0]  seg;
  logic [5:0]  an;
  logic        frame_tick;

  int n_checks = 0;
  int n_errors = 0;

  bcd_seg_scan #(.SCAN_DIV(SCAN_DIV), .BLANK_CYCLES(BLANK)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bcd_in     (bcd_in),
    .load       (load),
    .dp_mask    (dp_mask),
    .seg        (seg),
    .an         (an),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Active-low segment codes for digits 0-9; anything else shows a dash.
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] t [0:9];
    t[0] = 7'h40; t[1] = 7'h79; t[2] = 7'h24; t[3] = 7'h30; t[4] = 7'h19;
    t[5] = 7'h12; t[6] = 7'h02; t[7] = 7'h78; t[8] = 7'h00; t[9] = 7'h10;
    if (d > 4'd9) return 7'h3F;
    return t[d];
  endfunction

  function automatic logic lz_off(input logic [23:0] d, input logic [5:0] dp, input int s);
`ifdef LEADING_ZERO_BLANK_EN
    return (s > 0) && ((d >> (4 * s)) == 24'h0) && !dp[s];
`else
    return 1'b0;
`endif
  endfunction

  // Entered just after a frame_tick edge. Runs one full frame and leaves just after the next one.
  // When ld_idx >= 0, ld_val is loaded for the single clock at that point in the frame.
  task automatic run_frame(input string name, input logic [23:0] disp, input logic [5:0] dp,
                           input int ld_idx, input logic [23:0] ld_val);
    for (int i = 0; i < FRAME; i++) begin
      int s;
      int p;
      logic [5:0] e_an;
      logic [7:0] e_seg;
      s = i / SCAN_DIV;
      p = i % SCAN_DIV;
      if (i == ld_idx) begin
        load   = 1'b1;
        bcd_in = ld_val;
      end
      tick();
      load = 1'b0;
      if (p < BLANK || lz_off(disp, dp, s)) begin
        e_an  = 6'h3F;
        e_seg = 8'hFF;
      end else begin
        e_an  = ~(6'b000001 << s);
        e_seg = {~dp[s], seg_code(disp[4*s +: 4])};
      end
      check($sformatf("%s an s%0d p%0d", name, s, p), 32'(an), 32'(e_an));
      check($sformatf("%s seg s%0d p%0d", name, s, p), 32'(seg), 32'(e_seg));
      check($sformatf("%s tick i%0d", name, i), 32'(frame_tick), (i == FRAME - 1) ? 32'd1 : 32'd0);
    end
  endtask

  // Counts clocks from reset release (the release clock is clock 1) to the first frame_tick.
  task automatic wait_first_tick(input string name, input logic do_load, input logic [23:0] val);
    int n;
    if (do_load) begin
      load   = 1'b1;
      bcd_in = val;
    end
    tick();
    load = 1'b0;
    n = 1;
    while (frame_tick !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check({name, " first tick clock"}, 32'(n), 32'(FRAME));
  endtask

  initial begin
    rst_n   = 1'b0;
    load    = 1'b0;
    bcd_in  = 24'h0;
    dp_mask = 6'h00;
    #23;
    check("rst an", 32'(an), 32'h3F);
    check("rst seg", 32'(seg), 32'hFF);
    check("rst tick", 32'(frame_tick), 32'h0);
    tick();
    rst_n = 1'b1;

    wait_first_tick("boot", 1'b1, 24'h123456);
    run_frame("f123456", 24'h123456, 6'h00, 20, 24'h000042);
    run_frame("f42", 24'h000042, 6'h00, 10, 24'h000007);
    dp_mask = 6'b000100;
    run_frame("f7dp", 24'h000007, 6'b000100, FRAME - 1, 24'h999999);
    dp_mask = 6'h00;
    run_frame("f999999", 24'h999999, 6'h00, 5, 24'hA00000);
    run_frame("fA00000", 24'hA00000, 6'h00, -1, 24'h0);

    // Assert reset asynchronously while slot 3 is being scanned.
    repeat (3 * SCAN_DIV + 4) tick();
    check("pre-rst an slot3", 32'(an), 32'h37);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst an", 32'(an), 32'h3F);
    check("async rst seg", 32'(seg), 32'hFF);
    check("async rst tick", 32'(frame_tick), 32'h0);
    tick();
    rst_n = 1'b1;
    wait_first_tick("restart", 1'b0, 24'h0);
    run_frame("fzero", 24'h000000, 6'h00, -1, 24'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
